// File: rtl/seq_checker_pkg.sv
// Shared types and defaults for the sequence checker and its next-value block.
package seq_checker_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNTW_DEF  = 8;

  typedef logic [3:0] step_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_TRACK  = 2'd2,
    ST_RESYNC = 2'd3
  } state_t;

endpackage

// File: rtl/seq_checker_next.sv
// Combinational successor of a sequence value: restart at start after end,
// otherwise step up or down modulo 2^WIDTH.
module seq_next
  import seq_checker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] start_v,
  input  logic [WIDTH-1:0] last_v,
  input  step_t            step,
  input  logic             dir,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);

  logic [WIDTH-1:0] step_w;
  logic [WIDTH-1:0] stepped;

  assign step_w  = WIDTH'(step);
  assign stepped = dir ? (cur + step_w) : (cur - step_w);
  assign wrap    = (cur == last_v);
  assign nxt     = wrap ? start_v : stepped;

endmodule

// File: rtl/seq_checker.sv
// Checks a stream of qualified samples against a programmed arithmetic
// sequence, reporting lock, sticky error and saturating error/wrap counts.
module seq_checker
  import seq_checker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_end,
  input  logic [3:0]       cfg_step,
  input  logic             cfg_dir,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic             locked,
  output logic             err,
  output logic [CNTW-1:0]  err_count,
  output logic [CNTW-1:0]  wrap_count,
  output logic [WIDTH-1:0] expected
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (&c) ? c : c + CNTW'(1);
  endfunction

  // Reset asserts asynchronously and releases two edges after rst rises.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  state_t           state_p1, state_p0;
  logic             locked_p1, locked_p0;
  logic             err_p1, err_p0;
  logic [CNTW-1:0]  errc_p1, errc_p0;
  logic [CNTW-1:0]  wrapc_p1, wrapc_p0;
  logic [WIDTH-1:0] exp_p1, exp_p0;
  logic [WIDTH-1:0] start_p1, start_p0;
  logic [WIDTH-1:0] last_p1, last_p0;
  step_t            step_p1, step_p0;
  logic             dir_p1, dir_p0;

  logic [WIDTH-1:0] cur_v;
  logic [WIDTH-1:0] nxt_v;
  logic             nxt_wrap;

  // While acquiring, the matched value is the latched start, not expected.
  assign cur_v = (state_p1 == ST_TRACK) ? exp_p1 : start_p1;

  seq_next #(.WIDTH(WIDTH)) u_next (
    .cur     (cur_v),
    .start_v (start_p1),
    .last_v  (last_p1),
    .step    (step_p1),
    .dir     (dir_p1),
    .nxt     (nxt_v),
    .wrap    (nxt_wrap)
  );

  always_comb begin
    state_p0  = state_p1;
    locked_p0 = locked_p1;
    err_p0    = err_p1;
    errc_p0   = errc_p1;
    wrapc_p0  = wrapc_p1;
    exp_p0    = exp_p1;
    start_p0  = start_p1;
    last_p0   = last_p1;
    step_p0   = step_p1;
    dir_p0    = dir_p1;
    if (arm) begin
      start_p0  = cfg_start;
      last_p0   = cfg_end;
      step_p0   = cfg_step;
      dir_p0    = cfg_dir;
      locked_p0 = 1'b0;
      err_p0    = 1'b0;
      errc_p0   = '0;
      wrapc_p0  = '0;
      exp_p0    = cfg_start;
      state_p0  = ST_ARMED;
    end else if (sample_valid) begin
      case (state_p1)
        ST_ARMED, ST_RESYNC: begin
          if (sample == start_p1) begin
            locked_p0 = 1'b1;
            exp_p0    = nxt_v;
            state_p0  = ST_TRACK;
            if (nxt_wrap) wrapc_p0 = sat_inc(wrapc_p1);
          end
        end
        ST_TRACK: begin
          if (sample == exp_p1) begin
            exp_p0 = nxt_v;
            if (nxt_wrap) wrapc_p0 = sat_inc(wrapc_p1);
          end else begin
            locked_p0 = 1'b0;
            err_p0    = 1'b1;
            errc_p0   = sat_inc(errc_p1);
            state_p0  = ST_RESYNC;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p1: all architectural state and outputs.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_p1  <= ST_IDLE;
      locked_p1 <= 1'b0;
      err_p1    <= 1'b0;
      errc_p1   <= '0;
      wrapc_p1  <= '0;
      exp_p1    <= '0;
      start_p1  <= '0;
      last_p1   <= '0;
      step_p1   <= '0;
      dir_p1    <= 1'b0;
    end else begin
      state_p1  <= state_p0;
      locked_p1 <= locked_p0;
      err_p1    <= err_p0;
      errc_p1   <= errc_p0;
      wrapc_p1  <= wrapc_p0;
      exp_p1    <= exp_p0;
      start_p1  <= start_p0;
      last_p1   <= last_p0;
      step_p1   <= step_p0;
      dir_p1    <= dir_p0;
    end
  end

  assign locked     = locked_p1;
  assign err        = err_p1;
  assign err_count  = errc_p1;
  assign wrap_count = wrapc_p1;
  assign expected   = exp_p1;

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker with a behavioural sequence model and a
// per-cycle output comparison.
module tb_seq_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic [15:0] cfg_start = '0;
  logic [15:0] cfg_end = '0;
  logic [3:0]  cfg_step = '0;
  logic        cfg_dir = 1'b0;
  logic [15:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        locked, err;
  logic [7:0]  err_count, wrap_count;
  logic [15:0] expected;

  seq_checker dut (
    .clk(clk), .rst(rst), .arm(arm), .cfg_start(cfg_start), .cfg_end(cfg_end),
    .cfg_step(cfg_step), .cfg_dir(cfg_dir), .sample(sample),
    .sample_valid(sample_valid), .locked(locked), .err(err),
    .err_count(err_count), .wrap_count(wrap_count), .expected(expected)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural model: acquiring = waiting for start, tracking = following.
  bit          m_active, m_tracking;
  logic [15:0] m_start, m_end, m_exp;
  int          m_step;
  bit          m_dir, m_locked, m_err;
  int          m_errc, m_wrapc;

  task automatic m_reset();
    m_active = 0; m_tracking = 0; m_start = 0; m_end = 0; m_exp = 0;
    m_step = 0; m_dir = 0; m_locked = 0; m_err = 0; m_errc = 0; m_wrapc = 0;
  endtask

  task automatic m_advance(input logic [15:0] v);
    if (v == m_end) begin
      if (m_wrapc < 255) m_wrapc++;
      m_exp = m_start;
    end else if (m_dir) begin
      m_exp = 16'((int'(v) + m_step) % 65536);
    end else begin
      m_exp = 16'((int'(v) - m_step + 65536) % 65536);
    end
  endtask

  task automatic m_step_cycle(input bit a, input bit v, input logic [15:0] s);
    if (a) begin
      m_active = 1; m_tracking = 0;
      m_start = cfg_start; m_end = cfg_end; m_step = int'(cfg_step); m_dir = cfg_dir;
      m_locked = 0; m_err = 0; m_errc = 0; m_wrapc = 0; m_exp = cfg_start;
    end else if (v && m_active) begin
      if (!m_tracking) begin
        if (s == m_start) begin
          m_locked = 1; m_tracking = 1;
          m_advance(m_start);
        end
      end else if (s == m_exp) begin
        m_advance(m_exp);
      end else begin
        m_locked = 0; m_err = 1; m_tracking = 0;
        if (m_errc < 255) m_errc++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("locked", int'(locked), int'(m_locked));
      chk("err", int'(err), int'(m_err));
      chk("err_count", int'(err_count), m_errc);
      chk("wrap_count", int'(wrap_count), m_wrapc);
      chk("expected", int'(expected), int'(m_exp));
    end
  end

  task automatic cyc(input bit a, input bit v, input logic [15:0] s);
    arm = a; sample_valid = v; sample = s;
    @(posedge clk);
    m_step_cycle(a, v, s);
    #1;
    arm = 0; sample_valid = 0;
  endtask

  task automatic set_cfg(input logic [15:0] st, input logic [15:0] en,
                         input logic [3:0] sp, input logic d);
    cfg_start = st; cfg_end = en; cfg_step = sp; cfg_dir = d;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cyc(0, 0, 16'd0);
  endtask

  initial begin
    m_reset();
    #2 rst = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", int'(locked), 0);
    chk("rst_expected", int'(expected), 0);
    chk("rst_wrap", int'(wrap_count), 0);
    release_reset();

    // Samples in IDLE are ignored.
    cyc(0, 1, 16'd0);
    cyc(0, 1, 16'd5);
    chk("idle_locked", int'(locked), 0);

    // Up-count with a sequence restart.
    set_cfg(16'd0, 16'd36, 4'd2, 1'b1);
    cyc(1, 0, 16'd0);
    chk("armed_expected", int'(expected), 0);
    for (int v = 0; v <= 36; v += 2) cyc(0, 1, 16'(v));
    cyc(0, 0, 16'd0);
    cyc(0, 1, 16'd0);
    cyc(0, 1, 16'd2);
    chk("up_locked", int'(locked), 1);
    chk("up_err", int'(err), 0);
    chk("up_wrap", int'(wrap_count), 1);
    chk("up_expected", int'(expected), 4);

    // Down-count with a sequence restart; cfg changes without arm are inert.
    set_cfg(16'd93, 16'd13, 4'd4, 1'b0);
    cyc(1, 0, 16'd0);
    set_cfg(16'd1, 16'd2, 4'd1, 1'b1);
    for (int v = 93; v >= 13; v -= 4) cyc(0, 1, 16'(v));
    cyc(0, 1, 16'd93);
    chk("dn_wrap", int'(wrap_count), 1);
    chk("dn_err", int'(err), 0);
    chk("dn_expected", int'(expected), 89);

    // Mismatch, resync, reacquire.
    set_cfg(16'd350, 16'd365, 4'd3, 1'b1);
    cyc(1, 0, 16'd0);
    cyc(0, 1, 16'd350);
    cyc(0, 1, 16'd353);
    cyc(0, 1, 16'd357);
    chk("mm_err", int'(err), 1);
    chk("mm_errc", int'(err_count), 1);
    chk("mm_locked", int'(locked), 0);
    cyc(0, 1, 16'd360);
    cyc(0, 1, 16'd350);
    cyc(0, 1, 16'd353);
    chk("rs_locked", int'(locked), 1);
    chk("rs_err", int'(err), 1);
    chk("rs_errc", int'(err_count), 1);

    // Modular arithmetic wrap across 2^16.
    set_cfg(16'd65534, 16'd5, 4'd3, 1'b1);
    cyc(1, 0, 16'd0);
    cyc(0, 1, 16'd65534);
    cyc(0, 1, 16'd1);
    cyc(0, 1, 16'd4);
    chk("mod_err", int'(err), 0);
    chk("mod_wrap", int'(wrap_count), 0);
    chk("mod_expected", int'(expected), 7);

    // arm together with a valid sample while tracking with two errors.
    set_cfg(16'd100, 16'd200, 4'd5, 1'b1);
    cyc(1, 0, 16'd0);
    cyc(0, 1, 16'd100);
    cyc(0, 1, 16'd1);
    cyc(0, 1, 16'd100);
    cyc(0, 1, 16'd2);
    cyc(0, 1, 16'd100);
    chk("pre_arm_errc", int'(err_count), 2);
    set_cfg(16'd40, 16'd60, 4'd1, 1'b0);
    cyc(1, 1, 16'd40);
    chk("arm_errc", int'(err_count), 0);
    chk("arm_err", int'(err), 0);
    chk("arm_locked", int'(locked), 0);
    chk("arm_expected", int'(expected), 40);
    cyc(0, 1, 16'd40);
    chk("arm_relock", int'(locked), 1);
    chk("arm_next", int'(expected), 39);

    // Constant sequence: every match is a wrap; wrap counter saturates.
    set_cfg(16'd7, 16'd7, 4'd0, 1'b1);
    cyc(1, 0, 16'd0);
    repeat (300) cyc(0, 1, 16'd7);
    chk("sat_wrap", int'(wrap_count), 255);
    chk("sat_wrap_exp", int'(expected), 7);

    // Error counter saturation.
    set_cfg(16'd10, 16'd20, 4'd1, 1'b1);
    cyc(1, 0, 16'd0);
    repeat (260) begin
      cyc(0, 1, 16'd10);
      cyc(0, 1, 16'd99);
    end
    chk("sat_errc", int'(err_count), 255);

    // Asynchronous reset mid-TRACK, between edges.
    set_cfg(16'd0, 16'd36, 4'd2, 1'b1);
    cyc(1, 0, 16'd0);
    cyc(0, 1, 16'd0);
    cyc(0, 1, 16'd2);
    #1;
    rst = 1'b0;
    m_reset();
    #1;
    chk("ar_locked", int'(locked), 0);
    chk("ar_expected", int'(expected), 0);
    chk("ar_err", int'(err), 0);
    release_reset();
    cyc(0, 1, 16'd0);
    cyc(0, 1, 16'd4);
    chk("post_rst_locked", int'(locked), 0);
    chk("post_rst_expected", int'(expected), 0);
    cyc(1, 0, 16'd0);
    cyc(0, 1, 16'd0);
    chk("post_rst_relock", int'(locked), 1);

    repeat (2) @(posedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample/bound width in bits.
REQ-002 SHALL have parameter CNTW, default 8, width of the saturating error and wrap counters.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port arm  input  1  one-cycle request: capture the configuration and restart checking.
REQ-006 SHALL have port cfg_start  input  WIDTH  first value of the expected sequence.
REQ-007 SHALL have port cfg_end  input  WIDTH  last value before the sequence restarts at cfg_start.
REQ-008 SHALL have port cfg_step  input  4  unsigned increment magnitude; 0 is legal and means a constant sequence.
REQ-009 SHALL have port cfg_dir  input  1  1 = count up (add step), 0 = count down (subtract step).
REQ-010 SHALL have port sample  input  WIDTH  observed counter value.
REQ-011 SHALL have port sample_valid  input  1  sample is qualified this cycle.
REQ-012 SHALL have port locked  output  1  checker is tracking and the last sample matched.
REQ-013 SHALL have port err  output  1  sticky mismatch flag.
REQ-014 SHALL have port err_count  output  CNTW  mismatches since arm/reset; saturates at all-ones.
REQ-015 SHALL have port wrap_count  output  CNTW  completed sequence restarts since arm/reset; saturates at all-ones.
REQ-016 SHALL have port expected  output  WIDTH  value the next valid sample must equal.

Function
REQ-017 SHALL implement states IDLE, ARMED, TRACK and RESYNC.
REQ-018 IDLE: all samples SHALL be ignored; arm SHALL latch cfg_* into internal registers, clear err, err_count and wrap_count, and go to ARMED.
REQ-019 ARMED/RESYNC: a valid sample equal to latched start SHALL set locked=1, set expected=next(start) and go to TRACK; any other valid sample SHALL be ignored.
REQ-020 TRACK with a valid sample equal to expected: locked SHALL stay 1, and expected SHALL become next(expected).
REQ-021 TRACK with a valid sample not equal to expected: locked SHALL be 0, err SHALL be 1, err_count SHALL increment, and the state SHALL go to RESYNC.
REQ-022 next(v) SHALL be start if v == end, and in that case wrap_count SHALL increment when the v == end sample matched; otherwise next(v) SHALL be v +/- step, modulo 2^WIDTH.
REQ-023 If start == end, every matched sample SHALL count as a wrap.
REQ-024 All outputs SHALL be registered, updating on the edge that samples sample_valid (one-cycle latency); cycles without sample_valid SHALL hold all state.
REQ-025 arm SHALL have priority over sample in every state: when both are asserted on the same edge, the configuration is re-latched, counters and err clear, locked=0, the state becomes ARMED, and that sample is discarded.
REQ-026 cfg_* changes without arm SHALL have no effect.
REQ-027 Counters SHALL saturate at all-ones; a counter that has saturated SHALL not wrap to zero.
REQ-028 In IDLE and ARMED, expected SHALL show the latched start value.

Reset
REQ-029 rst low SHALL immediately force state=IDLE, locked=0, err=0, err_count=0, wrap_count=0, expected=0 and the latched configuration to 0, independent of clk.
REQ-030 Deassertion of rst SHALL be synchronised so that the first active edge is clean; a sample in flight when reset asserts SHALL be discarded.

Structure
REQ-031 The shared package SHALL hold the state enumeration, the WIDTH/CNTW defaults and the 4-bit step type.
REQ-032 The next-value computation (step, direction, wrap to start) SHALL be a combinational sub-module seq_next, reusable by the counter blocks.
REQ-033 The FSM, compare logic and saturating counters SHALL be in seq_checker; target size is 120-400 lines.

Verification
REQ-034 arm with start=0, end=36, step=2, dir=1, then feed samples 0,2,...,36,0,2 -> locked=1 from the first sample, err=0, wrap_count=1, expected=4 at the end.
REQ-035 arm with start=93, end=13, step=4, dir=0, then feed 93,89,...,13,93 -> wrap_count=1, err=0, and expected=89 after the last sample.
REQ-036 arm with start=350, end=365, step=3, then feed 350,353,357 -> err=1, err_count=1, locked=0 (RESYNC); then feed 360,350,353 -> locked=1, err still 1, err_count=1.
REQ-037 arm with start=65534, end=5, step=3, dir=1, then feed 65534,1,4 -> no error, and expected=7 (modular wrap, not a sequence wrap).
REQ-038 arm and sample_valid asserted together while in TRACK with err_count=2 -> counters=0, err=0, state ARMED, and the sample is ignored.
REQ-039 rst pulled low mid-TRACK between clock edges -> all outputs 0 immediately; the samples that follow are ignored until the next arm.
